regfile_bypass_sb: RTL
======================

Name: regfile_bypass_sb

Overview:
- Parametrised successor to the 32x32 register bank.
- Configurable data width and register count, two combinational read ports, one write port.
- Optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Integrated busy-bit scoreboard: the decode stage marks a destination pending at issue, writeback clears it, and hazard outputs feed the pipeline stall logic.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers; power of two, ≥2.
- ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS). Elaboration error otherwise.
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports combinationally; 0 = reads see the stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked busy; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en_i  in  1  writeback enable
- rd_addr_i  in  ADDR_WIDTH  writeback destination index
- data_i  in  DATA_WIDTH  writeback data
- rs1_addr_i  in  ADDR_WIDTH  read port 1 index
- rs2_addr_i  in  ADDR_WIDTH  read port 2 index
- rs1_data_o  out  DATA_WIDTH  read port 1 data
- rs2_data_o  out  DATA_WIDTH  read port 2 data
- issue_en_i  in  1  decode issues an instruction that will write issue_rd_i
- issue_rd_i  in  ADDR_WIDTH  destination being marked pending
- rs1_busy_o  out  1  read port 1 source has an outstanding producer
- rs2_busy_o  out  1  read port 2 source has an outstanding producer
- hazard_o  out  1  rs1_busy_o OR rs2_busy_o
- pending_cnt_o  out  ADDR_WIDTH+1  number of busy bits currently set

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - all registers = 0; all busy bits = 0; pending_cnt_o = 0.
  - Read data outputs therefore show 0; busy/hazard outputs = 0.
  - Deassertion is sampled on the next clk edge.
  - Reset mid-operation discards all pending writes and issues in that cycle.
- Write: on posedge, if wr_en_i and not (ZERO_REG and rd_addr_i==0), then reg[rd_addr_i] <= data_i. Write latency 1 cycle.
- Read: combinational, zero latency.
  - rsN_data_o = 0 if ZERO_REG and rsN_addr_i==0.
  - Else data_i if BYPASS and wr_en_i and rd_addr_i==rsN_addr_i (and the write is not suppressed).
  - Else reg[rsN_addr_i].
- Scoreboard, per posedge:
  - Clear: wr_en_i clears busy[rd_addr_i].
  - Set: issue_en_i sets busy[issue_rd_i].
  - Same index both cleared and set in one cycle: set wins (a new producer is outstanding after the old writeback).
  - ZERO_REG=1: index 0 is never set.
  - Issue to an already-busy register: remains set; count does not increment.
  - Write to a non-busy register: legal; busy unchanged; count unchanged.
- Busy outputs (combinational):
  - rsN_busy_o = busy[rsN_addr_i], masked to 0 when BYPASS and a non-suppressed write to that index occurs this cycle (value is forwarded).
  - With BYPASS=0 no masking; busy holds until the edge after writeback.
  - ZERO_REG=1: rsN_addr_i==0 always reports not busy.
- pending_cnt_o: registered popcount of busy bits, updated on the same edge as the busy bits. Range 0..NUM_REGS, never wraps.
- Unknown or out-of-range addresses cannot occur (index width is exact).

Test Plan:
- Reset: drive random writes/issues, pull rst_n low between edges → all reads 0, hazard_o=0 and pending_cnt_o=0 immediately, before the next edge.
- Write/read: write 0xDEADBEEF to r5; next cycle rs1=5, rs2=5 → both read 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0 (ZERO_REG=1).
- Bypass: r7 holds 0x11; same cycle wr_en_i to r7 with 0x22 and rs2_addr=7 → rs2_data_o=0x22 when BYPASS=1, 0x11 when BYPASS=0. Next cycle reads 0x22 in both configurations.
- Scoreboard: issue r3 → next cycle rs1=3 gives rs1_busy_o=1, hazard_o=1, pending_cnt_o=1. Writeback r3 → busy masked that cycle (BYPASS=1); after the edge busy=0 and count=0.
- Simultaneous: r9 busy; same edge writeback r9 and issue r9 → r9 stays busy, count unchanged. Issue r0 → count stays 0.
- Parametric: DATA_WIDTH=64, NUM_REGS=16, ADDR_WIDTH=4. Issue all 15 non-zero registers → pending_cnt_o=15. Write 0xFFFF_FFFF_0000_0001 to r15 → reads back exactly.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file: two combinational read ports, one write port, optional
// write-to-read bypass, optional hardwired zero register and a busy-bit scoreboard.
module regfile_bypass_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  input  logic                  issue_en_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  hazard_o,
  output logic [ADDR_WIDTH:0]   pending_cnt_o
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
      ADDR_WIDTH != $clog2(NUM_REGS)) begin : g_param_err
    $error("regfile_bypass_sb: NUM_REGS must be a power of two >= 2 and ADDR_WIDTH = clog2");
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  wr_ok, issue_ok;

  // While reset is held, in-flight writes/issues are discarded, so they must not bypass either.
  assign wr_ok    = rst_n && wr_en_i && !(ZERO_REG != 0 && rd_addr_i == '0);
  assign issue_ok = rst_n && issue_en_i && !(ZERO_REG != 0 && issue_rd_i == '0);

  logic [ADDR_WIDTH-1:0] rs_addr [2];
  logic [DATA_WIDTH-1:0] rs_data [2];
  logic                  rs_busy [2];

  assign rs_addr[0] = rs1_addr_i;
  assign rs_addr[1] = rs2_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = regs_q[rs_addr[p]];
      rs_busy[p] = busy_q[rs_addr[p]];
      if (BYPASS != 0 && wr_ok && rd_addr_i == rs_addr[p]) begin
        rs_data[p] = data_i;
        rs_busy[p] = 1'b0;
      end
      if (ZERO_REG != 0 && rs_addr[p] == '0) begin
        rs_data[p] = '0;
        rs_busy[p] = 1'b0;
      end
    end
  end

  assign rs1_data_o    = rs_data[0];
  assign rs2_data_o    = rs_data[1];
  assign rs1_busy_o    = rs_busy[0];
  assign rs2_busy_o    = rs_busy[1];
  assign hazard_o      = rs_busy[0] | rs_busy[1];
  assign pending_cnt_o = cnt_q;

  // Set is applied after clear so a re-issue to the written-back index stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)    busy_d[rd_addr_i]  = 1'b0;
    if (issue_ok) busy_d[issue_rd_i] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) regs_q[rd_addr_i] <= data_i;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
